// File: rtl/lgn_pixel_packer.sv
// Purpose : binarise 8-bit grayscale pixels against THRESHOLD, pack 8 per byte into the
//           classifier shift-in port, then flag result_valid once a full frame has settled.
// Latency : byte written (wr_en) the cycle after its 8th pixel; result_valid 2 cycles after
//           the final pixel (2+SETTLE_CYCLES when LGN_PACKER_SETTLE_EN is defined).
// Backpressure: pix_ready drops only while the frame settles; pix_valid gaps simply stall.
//
// Optional feature macro: LGN_PACKER_SETTLE_EN -- multi-cycle settle counter before
// result_valid. Without it the settle phase lasts exactly one cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pix_valid/pix_ready   pixel handshake; pix_data grayscale, pix_last marks final pixel
//   wr_en, wr_data        one-cycle write strobe + packed byte to the classifier
//   result_valid          classifier outputs reflect the last complete frame
//   frame_err             one-cycle pulse on a framing error
//   busy                  frame partially loaded or settling
module lgn_pixel_packer #(
    parameter int PIXELS        = 784,
    parameter int THRESHOLD     = 128,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    output logic       pix_ready,
    output logic       wr_en,
    output logic [7:0] wr_data,
    output logic       result_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            PW       = $clog2(PIXELS);
    localparam logic [PW-1:0] LAST_IDX = PW'(PIXELS - 1);
    localparam logic [7:0]    THR      = 8'(THRESHOLD);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pcnt, pcnt_nx;
    // First seven bits of the current group; the oldest pixel sits in bit 6.
    logic [6:0]    bitbuf, bitbuf_nx;
    logic          wr_en_nx;
    logic [7:0]    wr_data_nx;
    logic          frame_err_nx;
    logic          result_valid_nx;
    logic          busy_nx;

    logic          accept;
    logic          pix_bit;
    logic          at_last_idx;
    logic          group_end;
    logic          settle_done;

`ifdef LGN_PACKER_SETTLE_EN
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    logic [SW-1:0] scnt, scnt_nx;
    assign settle_done = (scnt == '0);
`else
    // Single-cycle settle: leave SETTLE on the first cycle spent there.
    assign settle_done = 1'b1;
`endif

    assign pix_ready   = rst_n && (state != SETTLE);
    assign accept      = pix_valid && pix_ready;
    assign pix_bit     = (pix_data >= THR);
    assign at_last_idx = (pcnt == LAST_IDX);
    assign group_end   = &pcnt[2:0];

    always_comb begin
        state_nx     = state;
        pcnt_nx      = pcnt;
        bitbuf_nx    = bitbuf;
        wr_en_nx     = 1'b0;
        wr_data_nx   = wr_data;
        frame_err_nx = 1'b0;
`ifdef LGN_PACKER_SETTLE_EN
        scnt_nx      = scnt;
`endif
        case (state)
            SETTLE: begin
                if (settle_done) begin
                    state_nx = HOLD;
                end
`ifdef LGN_PACKER_SETTLE_EN
                else begin
                    scnt_nx = scnt - 1'b1;
                end
`endif
            end
            default: begin
                // COLLECT and HOLD both accept; pcnt is already 0 in HOLD, so the
                // first pixel accepted there naturally becomes pixel 0 of a new frame.
                if (accept) begin
                    if (pix_last != at_last_idx) begin
                        // Framing error: drop the partial group and restart the frame.
                        frame_err_nx = 1'b1;
                        pcnt_nx      = '0;
                        bitbuf_nx    = '0;
                        state_nx     = COLLECT;
                    end else begin
                        if (group_end) begin
                            wr_en_nx   = 1'b1;
                            wr_data_nx = {bitbuf, pix_bit};
                            bitbuf_nx  = '0;
                        end else begin
                            bitbuf_nx  = {bitbuf[5:0], pix_bit};
                        end
                        if (at_last_idx) begin
                            pcnt_nx  = '0;
                            state_nx = SETTLE;
`ifdef LGN_PACKER_SETTLE_EN
                            scnt_nx  = SW'(SETTLE_CYCLES);
`endif
                        end else begin
                            pcnt_nx  = pcnt + 1'b1;
                            state_nx = COLLECT;
                        end
                    end
                end
            end
        endcase

        // Registered status flags are derived from the next state so they line up
        // with the state/counter values they describe.
        result_valid_nx = (state_nx == HOLD);
        busy_nx         = (pcnt_nx != '0) || (state_nx == SETTLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= COLLECT;
            pcnt         <= '0;
            bitbuf       <= '0;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            frame_err    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef LGN_PACKER_SETTLE_EN
            scnt         <= '0;
`endif
        end else begin
            state        <= state_nx;
            pcnt         <= pcnt_nx;
            bitbuf       <= bitbuf_nx;
            wr_en        <= wr_en_nx;
            wr_data      <= wr_data_nx;
            frame_err    <= frame_err_nx;
            result_valid <= result_valid_nx;
            busy         <= busy_nx;
`ifdef LGN_PACKER_SETTLE_EN
            scnt         <= scnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_lgn_pixel_packer.sv
// Purpose : directed + randomised checks of lgn_pixel_packer against a byte-packing model.
// Latency : expects wr_en one cycle after each 8th pixel, result_valid per settle config.
// Backpressure: drives random pix_valid gaps and holds pix_valid high through settle.
module tb_lgn_pixel_packer;

    localparam int PIXELS = 784;
    localparam int NBYTES = PIXELS / 8;
    localparam int SETTLE = 4;
`ifdef LGN_PACKER_SETTLE_EN
    localparam int RV_OFF = 1 + SETTLE;
`else
    localparam int RV_OFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       pix_ready;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       result_valid;
    logic       frame_err;
    logic       busy;

    int         n_asrt = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] got[$];
    logic [7:0] frame_pix [PIXELS];

    lgn_pixel_packer #(
        .PIXELS        (PIXELS),
        .THRESHOLD     (128),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_last     (pix_last),
        .pix_ready    (pix_ready),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .result_valid (result_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collect every written byte, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) got.push_back(wr_data);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pixel i of a group lands at bit 7-i when it meets the threshold.
    function automatic logic [7:0] pack(input int g);
        int v;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            if (frame_pix[g*8 + i] >= 8'd128) v = v + (1 << (7 - i));
        end
        return 8'(v);
    endfunction

    // Called just after a rising edge; returns the cycle number of the edge that took it.
    task automatic send_pixel(input logic [7:0] d, input logic l, output int acc);
        bit seen;
        seen      = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        for (int w = 0; w < 50 && !seen; w++) begin
            @(negedge clk);
            seen = (pix_ready === 1'b1);
        end
        chk("ready_wait", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        acc       = cyc;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_range(input int from, input int to_excl, input int last_idx,
                              input int gap_pct, output int first_acc, output int last_acc);
        int a;
        first_acc = 0;
        last_acc  = 0;
        for (int i = from; i < to_excl; i++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
                repeat ($urandom_range(1, 3)) tick();
            send_pixel(frame_pix[i], (i == last_idx), a);
            if (i == from) first_acc = a;
            last_acc = a;
        end
    endtask

    // Waits for result_valid after the final pixel; optionally keeps pix_valid high
    // through the settle phase, which must never be accepted.
    task automatic wait_result(input int acc, input bit hold);
        int rise;
        rise = -1;
        if (hold) begin
            pix_valid = 1'b1;
            pix_data  = 8'h55;
            pix_last  = 1'b0;
        end
        for (int k = 0; k < SETTLE + 20 && rise < 0; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                rise      = cyc;
                pix_valid = 1'b0;
            end else begin
                chk("ready_in_settle", pix_ready, 0);
                chk("busy_in_settle", busy, 1);
            end
        end
        pix_valid = 1'b0;
        chk("rv_latency", rise - acc, RV_OFF);
        tick();
    endtask

    task automatic check_bytes(input int n, input string tag);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got[i], pack(i));
    endtask

    task automatic fill_rand();
        for (int i = 0; i < PIXELS; i++) frame_pix[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int f, l, a;
        logic [7:0] b0;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        pix_last  = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pix_ready", pix_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("release_pix_ready", pix_ready, 1);

        // Full frame, alternating 0xFF/0x00, back-to-back, pix_valid held during settle
        for (int i = 0; i < PIXELS; i++) frame_pix[i] = (i % 2 == 0) ? 8'hFF : 8'h00;
        got.delete();
        send_range(0, PIXELS, PIXELS - 1, 0, f, l);
        chk("throughput", l - f, PIXELS - 1);
        wait_result(l, 1'b1);
        check_bytes(NBYTES, "alt");
        b0 = (got.size() == NBYTES) ? got[NBYTES-1] : 8'hxx;
        chk("alt_last_byte", b0, 8'hAA);

        // Threshold edge in group 0, starting from HOLD, random gaps across the frame
        fill_rand();
        frame_pix[0] = 8'd127; frame_pix[1] = 8'd128; frame_pix[2] = 8'd129;
        frame_pix[3] = 8'd0;   frame_pix[4] = 8'd255; frame_pix[5] = 8'd128;
        frame_pix[6] = 8'd127; frame_pix[7] = 8'd200;
        got.delete();
        chk("hold_result_valid", result_valid, 1);
        send_pixel(frame_pix[0], 1'b0, a);
        chk("hold_exit_rv_drop", result_valid, 0);
        chk("hold_exit_busy", busy, 1);
        send_range(1, PIXELS, PIXELS - 1, 30, f, l);
        wait_result(l, 1'b0);
        check_bytes(NBYTES, "thr");
        b0 = (got.size() > 0) ? got[0] : 8'hxx;
        chk("thr_byte0", b0, 8'h6D);

        // Early last on pixel 100
        fill_rand();
        got.delete();
        send_range(0, 101, 100, 0, f, l);
        chk("early_frame_err", frame_err, 1);
        chk("early_wr_en", wr_en, 0);
        chk("early_busy", busy, 0);
        chk("early_rv", result_valid, 0);
        tick();
        chk("early_err_pulse_end", frame_err, 0);
        tick();
        check_bytes(12, "early");

        // Following frame completes normally
        fill_rand();
        got.delete();
        send_range(0, PIXELS, PIXELS - 1, 20, f, l);
        wait_result(l, 1'b0);
        check_bytes(NBYTES, "after_err");

        // Missing last on pixel 783
        fill_rand();
        got.delete();
        send_range(0, PIXELS, -1, 0, f, l);
        chk("miss_frame_err", frame_err, 1);
        chk("miss_wr_en", wr_en, 0);
        chk("miss_rv", result_valid, 0);
        chk("miss_busy", busy, 0);
        repeat (10) tick();
        chk("miss_rv_stays_low", result_valid, 0);
        chk("miss_err_pulse_end", frame_err, 0);
        check_bytes(NBYTES - 1, "miss");

        // Reset at pixel 400, then a fresh frame
        fill_rand();
        got.delete();
        send_range(0, 400, -1, 0, f, l);
        rst_n = 1'b0;
        tick();
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_rv", result_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_ready", pix_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_release_ready", pix_ready, 1);
        fill_rand();
        got.delete();
        send_range(0, PIXELS, PIXELS - 1, 10, f, l);
        wait_result(l, 1'b0);
        check_bytes(NBYTES, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
